// File: rtl/mul_cdb_buffer_pkg.sv
// mul_cdb_buffer_pkg
//   Shared widths and the result packet carried from the multiplier to the
//   common data bus. Imported by mul_result_fifo and mul_cdb_buffer.
//   XLEN    : data width of a product.
//   PRF_LEN : physical register index width.
//   ROB_LEN : reorder buffer tag width.
//   STAGE   : multiplier pipeline depth (issue to mul_done, in cycles).
package mul_cdb_buffer_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;
  localparam int STAGE   = 8;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
  } MUL_RESULT_PACKET;

endpackage

// File: rtl/mul_result_fifo.sv
// mul_result_fifo
//   Circular FIFO of MUL_RESULT_PACKET entries with free-running wrapping
//   pointers and an explicit occupancy counter.
//   clock, reset : rising-edge clock, synchronous active-high reset.
//   clear        : synchronous flush (same effect as reset).
//   push, din    : write din at the tail; dropped when full and not popping.
//   pop          : retire the head entry; ignored when empty.
//   head         : entry at the head pointer (meaningful only when !empty).
//   empty, count : occupancy status, count in 0..DEPTH.
module mul_result_fifo
  import mul_cdb_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  MUL_RESULT_PACKET             din,
  output MUL_RESULT_PACKET             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  MUL_RESULT_PACKET mem [DEPTH];
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[head_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !clear) mem[tail_ptr] <= din;
  end

endmodule

// File: rtl/mul_cdb_buffer.sv
// mul_cdb_buffer
//   Completion buffer between the non-stalling pipelined multiplier and the
//   common data bus. Finished products are queued and offered to the CDB
//   arbiter until granted; issue credits guarantee that a product never meets
//   a full buffer; a shadow valid pipe discards products of squashed ops.
//
//   Optional feature macro: MUL_CDB_BYPASS_EN
//     defined   : an accepted product reaching an empty buffer is presented on
//                 the cdb_* outputs in the same cycle (written only if not
//                 granted that cycle).
//     undefined : cdb_* outputs come from FIFO state only (1-cycle latency).
//
//   Ports
//     clock, reset        : rising-edge clock, synchronous active-high reset.
//     squash              : branch-mispredict flush.
//     mul_issue           : RS_MUL issues an op this cycle (needs issue_ok).
//     mul_done, mul_value,
//     mul_prf_idx,
//     mul_rob_idx         : multiplier result pulse and its payload.
//     cdb_grant           : arbiter takes the head entry this cycle.
//     cdb_req, cdb_value,
//     cdb_prf_idx,
//     cdb_rob_idx         : head entry offered to the CDB (zero when empty).
//     issue_ok            : a credit is available for one more issue.
//
//   Handshake: cdb_req is the valid, cdb_grant the ready; an entry transfers
//   on a cycle where both are 1, and while cdb_req=1 without a grant the
//   offered payload holds steady. mul_issue is a valid whose ready is issue_ok.
module mul_cdb_buffer
  import mul_cdb_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = STAGE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  input  logic               mul_issue,
  input  logic               mul_done,
  input  logic [XLEN-1:0]    mul_value,
  input  logic [PRF_LEN-1:0] mul_prf_idx,
  input  logic [ROB_LEN-1:0] mul_rob_idx,
  input  logic               cdb_grant,
  output logic               cdb_req,
  output logic [XLEN-1:0]    cdb_value,
  output logic [PRF_LEN-1:0] cdb_prf_idx,
  output logic [ROB_LEN-1:0] cdb_rob_idx,
  output logic               issue_ok
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(LATENCY+1);
  localparam int SW = CW + IW;

  logic [LATENCY-1:0] shadow;
  logic [IW-1:0]      inflight;
  logic [IW-1:0]      squash_win;
  logic               flush;
  logic               accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [SW-1:0]      occupancy;
  MUL_RESULT_PACKET   mul_pkt;
  MUL_RESULT_PACKET   head_pkt;
  MUL_RESULT_PACKET   out_pkt;

  assign flush   = reset | squash;
  assign mul_pkt = '{value: mul_value, prf_idx: mul_prf_idx, rob_idx: mul_rob_idx};

  // A done pulse is genuine only if the matching shadow bit survived; pulses of
  // squashed ops arrive with that bit already cleared.
  assign accept = mul_done & shadow[LATENCY-1] & ~flush;

  // Every credit is either an in-flight op or an occupied entry, so the sum
  // bounds what can still land in the FIFO.
  assign occupancy = SW'(fifo_count) + SW'(inflight);
  assign issue_ok  = (occupancy < SW'(DEPTH));

  assign fifo_pop = ~fifo_empty & cdb_grant & ~flush;

`ifdef MUL_CDB_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty & accept;
  assign cdb_req   = ~fifo_empty | bypass;
  assign out_pkt   = !fifo_empty ? head_pkt : (bypass ? mul_pkt : '0);
  // A bypassed product granted in its arrival cycle never needs storage.
  assign fifo_push = accept & ~(bypass & cdb_grant);
`else
  assign cdb_req   = ~fifo_empty;
  assign out_pkt   = fifo_empty ? '0 : head_pkt;
  assign fifo_push = accept;
`endif

  assign cdb_value   = out_pkt.value;
  assign cdb_prf_idx = out_pkt.prf_idx;
  assign cdb_rob_idx = out_pkt.rob_idx;

  mul_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (squash),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mul_pkt),
    .head  (head_pkt),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (flush) begin
      shadow   <= '0;
      inflight <= '0;
    end else begin
      shadow <= {shadow[LATENCY-2:0], mul_issue};
      case ({mul_issue, shadow[LATENCY-1]})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // After a flush, products of ops issued before it may still emerge for up
  // to LATENCY cycles; those orphan pulses are expected, not protocol errors.
  always_ff @(posedge clock) begin
    if (flush)                 squash_win <= IW'(LATENCY);
    else if (squash_win != '0) squash_win <= squash_win - IW'(1);
  end

  always_ff @(posedge clock) begin
    if (!flush) begin
      assert (!(mul_issue && !issue_ok))
        else $error("mul_cdb_buffer: mul_issue without an issue credit");
      assert (!(accept && fifo_count == CW'(DEPTH) && !fifo_pop))
        else $error("mul_cdb_buffer: product arrived at a full buffer and was dropped");
      assert (!(mul_done && !shadow[LATENCY-1] && squash_win == '0))
        else $error("mul_cdb_buffer: mul_done with no matching in-flight op");
    end
  end

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// tb_mul_cdb_buffer
//   Directed bench for mul_cdb_buffer: reset state, single op latency,
//   back-pressure, grant coinciding with a push, squash of in-flight ops and
//   pointer wrap-around. A small multiplier model returns each issued op
//   exactly STAGE cycles later; a scoreboard queue holds the products the CDB
//   must deliver, in issue order.
module tb_mul_cdb_buffer;
  import mul_cdb_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = STAGE;
  localparam int PKW   = $bits(MUL_RESULT_PACKET);
`ifdef MUL_CDB_BYPASS_EN
  localparam int REQ_CYC = 8;
`else
  localparam int REQ_CYC = 9;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               squash;
  logic               mul_issue;
  logic               mul_done;
  logic [XLEN-1:0]    mul_value;
  logic [PRF_LEN-1:0] mul_prf_idx;
  logic [ROB_LEN-1:0] mul_rob_idx;
  logic               cdb_grant;
  logic               cdb_req;
  logic [XLEN-1:0]    cdb_value;
  logic [PRF_LEN-1:0] cdb_prf_idx;
  logic [ROB_LEN-1:0] cdb_rob_idx;
  logic               issue_ok;
  logic [PKW-1:0]     cdb_pkt;

  assign cdb_pkt = {cdb_value, cdb_prf_idx, cdb_rob_idx};

  mul_cdb_buffer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .mul_issue   (mul_issue),
    .mul_done    (mul_done),
    .mul_value   (mul_value),
    .mul_prf_idx (mul_prf_idx),
    .mul_rob_idx (mul_rob_idx),
    .cdb_grant   (cdb_grant),
    .cdb_req     (cdb_req),
    .cdb_value   (cdb_value),
    .cdb_prf_idx (cdb_prf_idx),
    .cdb_rob_idx (cdb_rob_idx),
    .issue_ok    (issue_ok)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int retired  = 0;

  logic [PKW-1:0] exp_q[$];

  typedef struct {
    int               due;
    MUL_RESULT_PACKET pkt;
  } pend_t;
  pend_t pend_q[$];

  logic           obs_req;
  logic [PKW-1:0] obs_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic MUL_RESULT_PACKET mk(input int v, input int p, input int r);
    MUL_RESULT_PACKET pk;
    pk.value   = XLEN'(v);
    pk.prf_idx = PRF_LEN'(p);
    pk.rob_idx = ROB_LEN'(r);
    return pk;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1: drives one cycle of inputs, samples outputs 1 time
  // unit later, scores any granted transfer, then advances to the next
  // posedge+1.
  task automatic tick(input bit want_issue, input MUL_RESULT_PACKET ipkt,
                      input bit grant, input bit sq);
    bit iss;
    iss       = want_issue && issue_ok && !sq;
    mul_issue = iss;
    cdb_grant = grant;
    squash    = sq;
    if (iss) begin
      pend_q.push_back('{cyc + LAT, ipkt});
      exp_q.push_back(ipkt);
    end
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      mul_done = 1'b1;
      {mul_value, mul_prf_idx, mul_rob_idx} = pend_q[0].pkt;
      void'(pend_q.pop_front());
    end else begin
      mul_done    = 1'b0;
      mul_value   = '0;
      mul_prf_idx = '0;
      mul_rob_idx = '0;
    end
    #1;
    obs_req = cdb_req;
    obs_pkt = cdb_pkt;
    if (cdb_req && grant && !sq) begin
      check("sb_result_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) check("sb_order", 64'(cdb_pkt), 64'(exp_q.pop_front()));
      retired++;
    end
    if (sq) exp_q.delete();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit grant);
    tick(1'b0, '0, grant, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int retired_before;
    int issued;
    reset       = 1'b1;
    squash      = 1'b0;
    mul_issue   = 1'b0;
    mul_done    = 1'b0;
    mul_value   = '0;
    mul_prf_idx = '0;
    mul_rob_idx = '0;
    cdb_grant   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    // Reset state
    check("reset_cdb_req", 64'(cdb_req), 64'(0));
    check("reset_issue_ok", 64'(issue_ok), 64'(1));
    check("reset_cdb_data", 64'(cdb_pkt), 64'(0));
    @(posedge clock);
    #1;
    repeat (3) idle(1'b0);
    check("idle_cdb_req", 64'(obs_req), 64'(0));
    check("idle_issue_ok", 64'(issue_ok), 64'(1));

    // Single op, grant held high
    tick(1'b1, mk(32'h15, 5, 3), 1'b1, 1'b0);
    check("single_req_t0", 64'(obs_req), 64'(0));
    for (int k = 1; k <= 10; k++) begin
      idle(1'b1);
      check($sformatf("single_req_t%0d", k), 64'(obs_req), 64'(k == REQ_CYC));
      if (k == REQ_CYC) check("single_data", 64'(obs_pkt), 64'(mk(32'h15, 5, 3)));
    end
    check("single_issue_ok", 64'(issue_ok), 64'(1));

    // Back-pressure: 8 issues, no grants
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_ok_before_%0d", i), 64'(issue_ok), 64'(1));
      tick(1'b1, mk(i, i, i), 1'b0, 1'b0);
    end
    check("bp_ok_exhausted", 64'(issue_ok), 64'(0));
    repeat (9) idle(1'b0);
    check("bp_ok_full", 64'(issue_ok), 64'(0));
    check("bp_req_full", 64'(obs_req), 64'(1));
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      check($sformatf("bp_drain_%0d", k), 64'(obs_pkt), 64'(mk(k, k, k)));
      if (k == 0) check("bp_credit_return", 64'(issue_ok), 64'(1));
    end
    idle(1'b0);
    check("bp_empty_req", 64'(obs_req), 64'(0));

    // Grant coinciding with accept while three entries are buffered
    for (int i = 0; i < 4; i++) tick(1'b1, mk(32'h100 + i, 10 + i, 20 + i), 1'b0, 1'b0);
    repeat (7) idle(1'b0);
    check("sim_ok_before", 64'(issue_ok), 64'(1));
    idle(1'b1);
    check("sim_head", 64'(obs_pkt), 64'(mk(32'h100, 10, 20)));
    check("sim_ok_after", 64'(issue_ok), 64'(1));
    for (int i = 1; i < 4; i++) begin
      idle(1'b1);
      check($sformatf("sim_order_%0d", i), 64'(obs_pkt), 64'(mk(32'h100 + i, 10 + i, 20 + i)));
    end
    idle(1'b0);
    check("sim_empty_req", 64'(obs_req), 64'(0));

    // Squash with four ops in flight; their late pulses must be dropped
    for (int i = 0; i < 4; i++) tick(1'b1, mk(32'h200 + i, 30 + i, i), 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      idle(1'b1);
      check($sformatf("sq_req_%0d", k), 64'(obs_req), 64'(0));
    end
    check("sq_issue_ok", 64'(issue_ok), 64'(1));
    // With inflight cleared, exactly DEPTH credits are available again.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sq_credit_%0d", i), 64'(issue_ok), 64'(1));
      tick(1'b1, mk(32'h300 + i, 40 + i, 8 + i), 1'b0, 1'b0);
    end
    check("sq_credit_exhausted", 64'(issue_ok), 64'(0));
    retired_before = retired;
    repeat (16) idle(1'b1);
    check("sq_refill_retired", 64'(retired - retired_before), 64'(8));
    check("sq_refill_drained", 64'(exp_q.size()), 64'(0));

    // Wrap-around: 3*DEPTH ops under random grants
    retired_before = retired;
    issued = 0;
    for (int n = 0; n < 3000 && (issued < 3 * DEPTH || exp_q.size() > 0 || pend_q.size() > 0); n++) begin
      bit want;
      want = (issued < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      if (want && issue_ok) issued++;
      tick(want, mk(int'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 31))),
           1'($urandom_range(0, 1)), 1'b0);
    end
    check("wrap_issued", 64'(issued), 64'(3 * DEPTH));
    check("wrap_retired", 64'(retired - retired_before), 64'(3 * DEPTH));
    check("wrap_drained", 64'(exp_q.size()), 64'(0));
    idle(1'b0);
    check("wrap_final_req", 64'(obs_req), 64'(0));
    check("wrap_final_ok", 64'(issue_ok), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
